// File: rtl/hbridge_deadband.sv
// H-bridge leg sequencer: turns drive/dir requests into gate-driver commands,
// inserting an all-off decay gap on every polarity reversal and latching over-on-time faults.
//
// state   | meaning
// COAST   | disarmed, all legs off
// BRAKE   | armed and idle, both low sides on
// DRIVE_L | left high side on, right low side on
// DRIVE_R | right high side on, left low side on
// DEAD    | all-off current decay between polarities
// FAULT   | drive pulse exceeded max on-time, held until disarmed
module hbridge_deadband #(
   parameter int DEAD_CYCLES   = 8,
   parameter int MAX_ON_CYCLES = 512
) (
   input  logic clk,
   input  logic reset,
   input  logic arm,
   input  logic drive,
   input  logic dir,
   output logic leftHigh,
   output logic leftEn,
   output logic rightHigh,
   output logic rightEn,
   output logic fault
);

   localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam int OW = $clog2(MAX_ON_CYCLES);
   localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);
   localparam logic [OW-1:0] ON_LAST   = OW'(MAX_ON_CYCLES - 1);

   typedef enum logic [2:0] {
      S_COAST,
      S_BRAKE,
      S_DRIVE_L,
      S_DRIVE_R,
      S_DEAD,
      S_FAULT
   } state_t;

   state_t          state_q, state_d;
   logic            last_dir_q, last_dir_d;
   logic [DW-1:0]   dead_cnt_q, dead_cnt_d;
   logic [OW-1:0]   on_cnt_q, on_cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_COAST;
         last_dir_q <= 1'b0;
         dead_cnt_q <= '0;
         on_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         last_dir_q <= last_dir_d;
         dead_cnt_q <= dead_cnt_d;
         on_cnt_q   <= on_cnt_d;
      end
   end

   // on_cnt only survives while remaining in the same drive state, so every
   // entry into DRIVE_x starts from zero.
   always_comb begin
      state_d    = state_q;
      last_dir_d = last_dir_q;
      dead_cnt_d = dead_cnt_q;
      on_cnt_d   = '0;
      if (!arm) begin
         state_d = S_COAST;
      end else begin
         unique case (state_q)
            S_COAST: state_d = S_BRAKE;
            S_BRAKE: begin
               if (drive) begin
                  if (dir == last_dir_q) begin
                     state_d = dir ? S_DRIVE_L : S_DRIVE_R;
                  end else begin
                     state_d    = S_DEAD;
                     dead_cnt_d = DEAD_LOAD;
                  end
               end
            end
            S_DRIVE_L, S_DRIVE_R: begin
               if (!drive) begin
                  state_d = S_BRAKE;
               end else if (dir != last_dir_q) begin
                  state_d    = S_DEAD;
                  dead_cnt_d = DEAD_LOAD;
               end else if (on_cnt_q == ON_LAST) begin
                  state_d = S_FAULT;
               end else begin
                  on_cnt_d = on_cnt_q + 1'b1;
               end
            end
            S_DEAD: begin
               if (dead_cnt_q == '0) begin
                  last_dir_d = dir;
                  if (drive) state_d = dir ? S_DRIVE_L : S_DRIVE_R;
                  else       state_d = S_BRAKE;
               end else begin
                  dead_cnt_d = dead_cnt_q - 1'b1;
               end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_COAST;
         endcase
      end
   end

   always_comb begin
      {leftHigh, leftEn, rightHigh, rightEn, fault} = 5'b00000;
      unique case (state_q)
         S_COAST:   {leftHigh, leftEn, rightHigh, rightEn, fault} = 5'b00000;
         S_BRAKE:   {leftHigh, leftEn, rightHigh, rightEn, fault} = 5'b01010;
         S_DRIVE_L: {leftHigh, leftEn, rightHigh, rightEn, fault} = 5'b11010;
         S_DRIVE_R: {leftHigh, leftEn, rightHigh, rightEn, fault} = 5'b01110;
         S_DEAD:    {leftHigh, leftEn, rightHigh, rightEn, fault} = 5'b00000;
         S_FAULT:   {leftHigh, leftEn, rightHigh, rightEn, fault} = 5'b00001;
         default:   {leftHigh, leftEn, rightHigh, rightEn, fault} = 5'b00000;
      endcase
   end

endmodule

// File: tb/tb_hbridge_deadband.sv
// Directed self-checking bench for hbridge_deadband (DEAD_CYCLES=8, MAX_ON_CYCLES=512).
`timescale 1ns/1ps
module tb_hbridge_deadband;

   localparam logic [4:0] O_COAST = 5'b00000;
   localparam logic [4:0] O_BRAKE = 5'b01010;
   localparam logic [4:0] O_DRVL  = 5'b11010;
   localparam logic [4:0] O_DRVR  = 5'b01110;
   localparam logic [4:0] O_FAULT = 5'b00001;

   logic clk = 1'b0;
   logic reset, arm, drive, dir;
   logic leftHigh, leftEn, rightHigh, rightEn, fault;
   logic [4:0] out;
   int checks = 0;
   int errors = 0;

   assign out = {leftHigh, leftEn, rightHigh, rightEn, fault};

   hbridge_deadband #(.DEAD_CYCLES(8), .MAX_ON_CYCLES(512)) dut (
      .clk(clk), .reset(reset), .arm(arm), .drive(drive), .dir(dir),
      .leftHigh(leftHigh), .leftEn(leftEn), .rightHigh(rightHigh),
      .rightEn(rightEn), .fault(fault)
   );

   always #12.5 clk = ~clk;

   always @(negedge clk) begin
      checks++;
      if (leftHigh && rightHigh) begin
         errors++;
         $display("FAIL both_high t=%0t actual=%b required=not 11", $time, {leftHigh, rightHigh});
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; arm = 1'b1; drive = 1'b0; dir = 1'b0;
      tick();
      checks++;
      if (out !== O_COAST) begin errors++; $display("FAIL reset_out actual=%b required=%b", out, O_COAST); end
      reset = 1'b0;
      tick();
      checks++;
      if (out !== O_BRAKE) begin errors++; $display("FAIL reset_to_brake actual=%b required=%b", out, O_BRAKE); end
   endtask

   task automatic test_pwm;
      logic [4:0] exp;
      dir = 1'b0;
      for (int p = 0; p < 3; p++) begin
         for (int c = 0; c < 16; c++) begin
            drive = (c < 10);
            tick();
            exp = (c < 10) ? O_DRVR : O_BRAKE;
            checks++;
            if (out !== exp) begin errors++; $display("FAIL pwm p=%0d c=%0d actual=%b required=%b", p, c, out, exp); end
         end
      end
   endtask

   task automatic test_reversal;
      drive = 1'b1; dir = 1'b0;
      tick(); tick();
      checks++;
      if (out !== O_DRVR) begin errors++; $display("FAIL rev_pre actual=%b required=%b", out, O_DRVR); end
      dir = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (out !== O_COAST) begin errors++; $display("FAIL rev_dead i=%0d actual=%b required=%b", i, out, O_COAST); end
      end
      tick();
      checks++;
      if (out !== O_DRVL) begin errors++; $display("FAIL rev_after actual=%b required=%b", out, O_DRVL); end
   endtask

   task automatic run_to_fault(input string tag);
      int hc, fi;
      hc = 0; fi = -1;
      drive = 1'b0;
      tick();
      checks++;
      if (out !== O_BRAKE) begin errors++; $display("FAIL %s_brake actual=%b required=%b", tag, out, O_BRAKE); end
      drive = 1'b1; dir = 1'b1;
      for (int i = 0; i < 600; i++) begin
         tick();
         if (leftHigh) hc++;
         if (fault) begin fi = i; break; end
      end
      checks++;
      if (hc !== 512) begin errors++; $display("FAIL %s_high_cycles actual=%0d required=512", tag, hc); end
      checks++;
      if (fi !== 512) begin errors++; $display("FAIL %s_fault_cycle actual=%0d required=512", tag, fi); end
      checks++;
      if (out !== O_FAULT) begin errors++; $display("FAIL %s_fault_out actual=%b required=%b", tag, out, O_FAULT); end
   endtask

   task automatic test_fault;
      run_to_fault("flt");
      drive = 1'b0; dir = 1'b0;
      tick();
      drive = 1'b1;
      tick();
      checks++;
      if (out !== O_FAULT) begin errors++; $display("FAIL flt_sticky actual=%b required=%b", out, O_FAULT); end
      arm = 1'b0; drive = 1'b0;
      tick();
      checks++;
      if (out !== O_COAST) begin errors++; $display("FAIL flt_clear actual=%b required=%b", out, O_COAST); end
      arm = 1'b1;
      tick();
      checks++;
      if (out !== O_BRAKE) begin errors++; $display("FAIL flt_rearm actual=%b required=%b", out, O_BRAKE); end
   endtask

   // lastDir is 1 on entry; first scenario ends with lastDir=1, second with lastDir=0
   task automatic test_dead_ignore;
      drive = 1'b1; dir = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (out !== O_COAST) begin errors++; $display("FAIL dign_a i=%0d actual=%b required=%b", i, out, O_COAST); end
         if (i == 1) begin dir = 1'b1; drive = 1'b0; end
      end
      tick();
      checks++;
      if (out !== O_BRAKE) begin errors++; $display("FAIL dign_a_brake actual=%b required=%b", out, O_BRAKE); end
      drive = 1'b1; dir = 1'b1;
      tick();
      checks++;
      if (out !== O_DRVL) begin errors++; $display("FAIL dign_a_lastdir actual=%b required=%b", out, O_DRVL); end
      dir = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (out !== O_COAST) begin errors++; $display("FAIL dign_b i=%0d actual=%b required=%b", i, out, O_COAST); end
         if (i == 1) drive = 1'b0;
      end
      tick();
      checks++;
      if (out !== O_BRAKE) begin errors++; $display("FAIL dign_b_brake actual=%b required=%b", out, O_BRAKE); end
      drive = 1'b1;
      tick();
      checks++;
      if (out !== O_DRVR) begin errors++; $display("FAIL dign_b_lastdir actual=%b required=%b", out, O_DRVR); end
   endtask

   task automatic test_arm_drop;
      arm = 1'b0;
      tick();
      checks++;
      if (out !== O_COAST) begin errors++; $display("FAIL arm_drive actual=%b required=%b", out, O_COAST); end
      arm = 1'b1; drive = 1'b0;
      tick();
      checks++;
      if (out !== O_BRAKE) begin errors++; $display("FAIL arm_rearm actual=%b required=%b", out, O_BRAKE); end
      drive = 1'b1; dir = 1'b1;
      tick(); tick();
      checks++;
      if (out !== O_COAST) begin errors++; $display("FAIL arm_dead actual=%b required=%b", out, O_COAST); end
      arm = 1'b0;
      tick();
      checks++;
      if (out !== O_COAST) begin errors++; $display("FAIL arm_dead_coast actual=%b required=%b", out, O_COAST); end
      arm = 1'b1;
      tick();
      checks++;
      if (out !== O_BRAKE) begin errors++; $display("FAIL arm_dead_rearm actual=%b required=%b", out, O_BRAKE); end
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (out !== O_COAST) begin errors++; $display("FAIL arm_redead i=%0d actual=%b required=%b", i, out, O_COAST); end
      end
      tick();
      checks++;
      if (out !== O_DRVL) begin errors++; $display("FAIL arm_redead_end actual=%b required=%b", out, O_DRVL); end
      drive = 1'b0; dir = 1'b0;
      tick();
      checks++;
      if (out !== O_BRAKE) begin errors++; $display("FAIL simul_brake actual=%b required=%b", out, O_BRAKE); end
      drive = 1'b1;
      tick();
      checks++;
      if (out !== O_COAST) begin errors++; $display("FAIL simul_dead actual=%b required=%b", out, O_COAST); end
   endtask

   task automatic test_reset_mid;
      arm = 1'b0; drive = 1'b0;
      tick();
      arm = 1'b1;
      tick();
      run_to_fault("rst");
      reset = 1'b1;
      tick();
      checks++;
      if (out !== O_COAST) begin errors++; $display("FAIL rst_fault actual=%b required=%b", out, O_COAST); end
      reset = 1'b0; drive = 1'b0;
      tick();
      checks++;
      if (out !== O_BRAKE) begin errors++; $display("FAIL rst_rearm actual=%b required=%b", out, O_BRAKE); end
      drive = 1'b1; dir = 1'b0;
      tick();
      checks++;
      if (out !== O_DRVR) begin errors++; $display("FAIL rst_drive actual=%b required=%b", out, O_DRVR); end
      reset = 1'b1;
      tick();
      checks++;
      if (out !== O_COAST) begin errors++; $display("FAIL rst_mid_drive actual=%b required=%b", out, O_COAST); end
      reset = 1'b0; dir = 1'b1;
      tick();
      tick();
      checks++;
      if (out !== O_COAST) begin errors++; $display("FAIL rst_lastdir_cleared actual=%b required=%b", out, O_COAST); end
   endtask

   initial begin
      reset = 1'b1; arm = 1'b0; drive = 1'b0; dir = 1'b0;
      test_reset();
      test_pwm();
      test_reversal();
      test_fault();
      test_dead_ignore();
      test_arm_drop();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
